// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: block type codes, idle control character, receive FSM states.
// Used by both the encoder and the receive-side decoder.
package pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] BLOCK_TYPE_IDLE     = 8'h1e;
    localparam logic [7:0] BLOCK_TYPE_START_0  = 8'h78;
    localparam logic [7:0] BLOCK_TYPE_START_4  = 8'h33;
    localparam logic [7:0] BLOCK_TYPE_OS_4     = 8'h2d;
    localparam logic [7:0] BLOCK_TYPE_OS_START = 8'h66;
    localparam logic [7:0] BLOCK_TYPE_OS_OS    = 8'h55;
    localparam logic [7:0] BLOCK_TYPE_OS_0     = 8'h4b;
    localparam logic [7:0] BLOCK_TYPE_TERM_0   = 8'h87;
    localparam logic [7:0] BLOCK_TYPE_TERM_1   = 8'h99;
    localparam logic [7:0] BLOCK_TYPE_TERM_2   = 8'haa;
    localparam logic [7:0] BLOCK_TYPE_TERM_3   = 8'hb4;
    localparam logic [7:0] BLOCK_TYPE_TERM_4   = 8'hcc;
    localparam logic [7:0] BLOCK_TYPE_TERM_5   = 8'hd2;
    localparam logic [7:0] BLOCK_TYPE_TERM_6   = 8'he1;
    localparam logic [7:0] BLOCK_TYPE_TERM_7   = 8'hff;

    localparam logic [6:0] CTRL_IDLE = 7'h07;

    typedef enum logic [1:0] {
        RX_INIT,
        RX_C,
        RX_D,
        RX_E
    } rx_state_e;

    // Returns {hit, k}: hit is set when the type is one of the eight terminate codes.
    function automatic logic [3:0] term_lookup(input logic [7:0] block_type);
        case (block_type)
            BLOCK_TYPE_TERM_0: return 4'b1_000;
            BLOCK_TYPE_TERM_1: return 4'b1_001;
            BLOCK_TYPE_TERM_2: return 4'b1_010;
            BLOCK_TYPE_TERM_3: return 4'b1_011;
            BLOCK_TYPE_TERM_4: return 4'b1_100;
            BLOCK_TYPE_TERM_5: return 4'b1_101;
            BLOCK_TYPE_TERM_6: return 4'b1_110;
            BLOCK_TYPE_TERM_7: return 4'b1_111;
            default:           return 4'b0_000;
        endcase
    endfunction

endpackage

// File: rtl/pcs_dec_block_type.sv
// Combinational 66b block classifier: sync header + payload -> block kind, MAC-side data/keep,
// terminate position and decode error. Holds no state.
module pcs_dec_block_type
    import pcs_pkg::*;
#(
    parameter bit          IS_40G       = 1'b0,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned KEEP_W       = 8,
    parameter int unsigned BLOCK_TYPE_W = 8,
    parameter int unsigned CTRL_W       = 7
) (
    input  logic [1:0]        i_sync_head,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_data_v,
    output logic              o_ctrl_v,
    output logic              o_idle_v,
    output logic              o_start0_v,
    output logic              o_start4_v,
    output logic              o_term_v,
    output logic              o_dec_err,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep
);

    logic [BLOCK_TYPE_W-1:0] w_type;
    logic [3:0]              w_term;
    logic                    w_all_idle;
    logic [DATA_W-1:0]       w_shift;

    assign w_type  = i_data[BLOCK_TYPE_W-1:0];
    assign w_term  = term_lookup(w_type);
    assign w_shift = {8'h00, i_data[DATA_W-1:8]};

    always_comb begin
        w_all_idle = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i_data[BLOCK_TYPE_W + CTRL_W*i +: CTRL_W] != CTRL_IDLE) begin
                w_all_idle = 1'b0;
            end
        end
    end

    always_comb begin
        o_data_v   = 1'b0;
        o_ctrl_v   = 1'b0;
        o_idle_v   = 1'b0;
        o_start0_v = 1'b0;
        o_start4_v = 1'b0;
        o_term_v   = 1'b0;
        o_dec_err  = 1'b0;
        o_data     = '0;
        o_keep     = '0;
        case (i_sync_head)
            SYNC_DATA: begin
                o_data_v = 1'b1;
                o_data   = i_data;
                o_keep   = '1;
            end
            SYNC_CTRL: begin
                o_ctrl_v = 1'b1;
                if (w_type == BLOCK_TYPE_IDLE) begin
                    o_idle_v  = w_all_idle;
                    o_dec_err = !w_all_idle;
                end else if (w_type == BLOCK_TYPE_START_0) begin
                    o_start0_v = 1'b1;
                    o_data     = {i_data[DATA_W-1:8], 8'h00};
                    o_keep     = KEEP_W'(8'hfe);
                end else if (w_type == BLOCK_TYPE_START_4 && !IS_40G) begin
                    o_start4_v = 1'b1;
                    o_data     = {i_data[DATA_W-1:40], 40'h0};
                    o_keep     = KEEP_W'(8'he0);
                end else if (w_term[3]) begin
                    // Terminate: bytes below position k carry the tail of the frame.
                    o_term_v = 1'b1;
                    for (int i = 0; i < KEEP_W; i++) begin
                        if (i < int'(w_term[2:0])) begin
                            o_keep[i]       = 1'b1;
                            o_data[8*i +: 8] = w_shift[8*i +: 8];
                        end
                    end
                end else begin
                    o_dec_err = 1'b1;
                end
            end
            default: o_dec_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/pcs_dec_lite.sv
// 64b/66b receive decoder: classifies descrambled blocks, restores MAC data/keep and tracks framing
// with a reduced receive FSM. One registered output per valid input block, no backpressure.
module pcs_dec_lite
    import pcs_pkg::*;
#(
    parameter bit          IS_40G       = 1'b0,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned KEEP_W       = 8,
    parameter int unsigned LANE0_CNT_N  = IS_40G ? 1 : 2,
    parameter int unsigned BLOCK_TYPE_W = 8,
    parameter int unsigned CTRL_W       = 7,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic [1:0]             sync_head_i,
    input  logic [DATA_W-1:0]      data_i,
    output logic                   valid_o,
    output logic                   ctrl_v_o,
    output logic                   idle_v_o,
    output logic [LANE0_CNT_N-1:0] start_v_o,
    output logic                   term_v_o,
    output logic                   err_v_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [KEEP_W-1:0]      keep_o,
    output logic [ERR_CNT_W-1:0]   err_cnt_o
);

    logic              w_data_v;
    logic              w_ctrl_v;
    logic              w_idle_v;
    logic              w_start0_v;
    logic              w_start4_v;
    logic              w_term_v;
    logic              w_dec_err;
    logic [DATA_W-1:0] w_cls_data;
    logic [KEEP_W-1:0] w_cls_keep;

    pcs_dec_block_type #(
        .IS_40G       (IS_40G),
        .DATA_W       (DATA_W),
        .KEEP_W       (KEEP_W),
        .BLOCK_TYPE_W (BLOCK_TYPE_W),
        .CTRL_W       (CTRL_W)
    ) u_block_type (
        .i_sync_head (sync_head_i),
        .i_data      (data_i),
        .o_data_v    (w_data_v),
        .o_ctrl_v    (w_ctrl_v),
        .o_idle_v    (w_idle_v),
        .o_start0_v  (w_start0_v),
        .o_start4_v  (w_start4_v),
        .o_term_v    (w_term_v),
        .o_dec_err   (w_dec_err),
        .o_data      (w_cls_data),
        .o_keep      (w_cls_keep)
    );

    rx_state_e r_state;
    rx_state_e w_state_d;
    logic      w_start;

    assign w_start = w_start0_v | w_start4_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RX_INIT;
        end else if (valid_i) begin
            r_state <= w_state_d;
        end
    end

    // Decode errors never set a kind flag, so they always fall through to RX_E.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            RX_INIT, RX_C: begin
                if (w_idle_v)     w_state_d = RX_C;
                else if (w_start) w_state_d = RX_D;
                else              w_state_d = RX_E;
            end
            RX_D: begin
                if (w_data_v)      w_state_d = RX_D;
                else if (w_term_v) w_state_d = RX_C;
                else               w_state_d = RX_E;
            end
            RX_E: begin
                if (w_idle_v)     w_state_d = RX_C;
                else if (w_start) w_state_d = RX_D;
                else              w_state_d = RX_E;
            end
            default: w_state_d = RX_E;
        endcase
    end

    logic                   w_err;
    logic                   w_idle_d;
    logic                   w_term_d;
    logic [1:0]             w_start_all;
    logic [LANE0_CNT_N-1:0] w_start_d;
    logic [DATA_W-1:0]      w_data_d;
    logic [KEEP_W-1:0]      w_keep_d;

    assign w_start_all = {w_start4_v, w_start0_v};

    always_comb begin
        w_err     = w_dec_err | (w_state_d == RX_E);
        w_idle_d  = w_idle_v & ~w_err;
        w_term_d  = w_term_v & ~w_err;
        w_start_d = w_start_all[LANE0_CNT_N-1:0] & {LANE0_CNT_N{~w_err}};
        w_data_d  = w_err ? '0 : w_cls_data;
        w_keep_d  = w_err ? '0 : w_cls_keep;
    end

    logic                   r_valid;
    logic                   r_ctrl;
    logic                   r_idle;
    logic [LANE0_CNT_N-1:0] r_start;
    logic                   r_term;
    logic                   r_err;
    logic [DATA_W-1:0]      r_data;
    logic [KEEP_W-1:0]      r_keep;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_ctrl    <= 1'b0;
            r_idle    <= 1'b0;
            r_start   <= '0;
            r_term    <= 1'b0;
            r_err     <= 1'b0;
            r_data    <= '0;
            r_keep    <= '0;
            r_err_cnt <= '0;
        end else if (valid_i) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl_v;
            r_idle  <= w_idle_d;
            r_start <= w_start_d;
            r_term  <= w_term_d;
            r_err   <= w_err;
            r_data  <= w_data_d;
            r_keep  <= w_keep_d;
            if (w_err && r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end else begin
            // No block: strobes drop, data/keep/counter keep their last value.
            r_valid <= 1'b0;
            r_ctrl  <= 1'b0;
            r_idle  <= 1'b0;
            r_start <= '0;
            r_term  <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign valid_o   = r_valid;
    assign ctrl_v_o  = r_ctrl;
    assign idle_v_o  = r_idle;
    assign start_v_o = r_start;
    assign term_v_o  = r_term;
    assign err_v_o   = r_err;
    assign data_o    = r_data;
    assign keep_o    = r_keep;
    assign err_cnt_o = r_err_cnt;

endmodule
